// File: rtl/frame_crc_pkg.sv
// Shared types and the CRC-32 step function for the frame CRC monitor.
// The pixel-count field is sized for the widest supported counter (32 bits).
package frame_crc_pkg;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOR  = 32'hFFFFFFFF;

  localparam int REC_CNT_W    = 32;
  localparam int CRC_DATA_MAX = 64;

  typedef struct packed {
    logic [15:0]          frame;
    logic [REC_CNT_W-1:0] pix_cnt;
    logic [31:0]          crc;
    logic                 partial;
    logic [15:0]          pos_err;
  } frame_rec_t;

  // MSB-first update over the low 'width' bits of data, all in one step.
  function automatic logic [31:0] crc32_next(input logic [31:0]             crc,
                                             input logic [CRC_DATA_MAX-1:0] data,
                                             input int                      width);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = CRC_DATA_MAX - 1; i >= 0; i--) begin
      if (i < width) begin
        fb = c[31] ^ data[i];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_crc_fifo.sv
// First-word-fall-through record FIFO; DEPTH must be a power of two >= 2.
// A push while full is only taken when a pop happens on the same edge.
module frame_crc_fifo
  import frame_crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  frame_rec_t din,
  output frame_rec_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  frame_rec_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/frame_crc_monitor.sv
// Per-frame CRC-32 / pixel-count monitor on the pixel clock, records drained over valid/ready.
// Optional coordinate checker enabled by defining FRAME_CRC_POS_CHECK_EN.
module frame_crc_monitor
  import frame_crc_pkg::*;
#(
  parameter int   COLOR_W   = 4,
  parameter int   CORD_W    = 10,
  parameter int   PIX_CNT_W = 20,
  parameter int   DEPTH     = 4,
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic                 clk_pix,
  input  logic                 btn_rst,
  input  logic                 de,
  input  logic                 vsync,
  input  logic [CORD_W-1:0]    sx,
  input  logic [CORD_W-1:0]    sy,
  input  logic [COLOR_W-1:0]   r,
  input  logic [COLOR_W-1:0]   g,
  input  logic [COLOR_W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_frame,
  output logic [PIX_CNT_W-1:0] out_pix_cnt,
  output logic [31:0]          out_crc,
  output logic                 out_partial,
  output logic [15:0]          out_pos_err,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int PIX_W = 3 * COLOR_W;

  logic [PIX_W-1:0]     pix;
  logic                 vsync_q;
  logic                 frame_end;
  logic [31:0]          crc_q;
  logic [31:0]          crc_upd;
  logic [PIX_CNT_W-1:0] cnt_q;
  logic [PIX_CNT_W-1:0] cnt_upd;
  logic [15:0]          frame_q;
  logic                 partial_q;
  logic [15:0]          pos_err_upd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;
  frame_rec_t           rec_in;
  frame_rec_t           rec_head;
  frame_rec_t           shown;
  logic                 unused_cnt_hi;

  assign pix       = {r, g, b};
  assign frame_end = (vsync == VSYNC_ACT) && (vsync_q != VSYNC_ACT);

  // The de pixel on the frame-end cycle is folded into the closing frame.
  assign crc_upd = de ? crc32_next(crc_q, CRC_DATA_MAX'(pix), PIX_W) : crc_q;
  assign cnt_upd = (de && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  assign pop  = out_ready && !fifo_empty;
  assign drop = frame_end && fifo_full && !pop;

  always_ff @(posedge clk_pix or negedge btn_rst) begin
    if (!btn_rst) begin
      vsync_q   <= ~VSYNC_ACT;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      frame_q   <= '0;
      partial_q <= 1'b1;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      vsync_q <= vsync;
      if (frame_end) begin
        crc_q     <= CRC_INIT;
        cnt_q     <= '0;
        frame_q   <= frame_q + 16'd1;
        partial_q <= 1'b0;
      end else begin
        crc_q <= crc_upd;
        cnt_q <= cnt_upd;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef FRAME_CRC_POS_CHECK_EN
  logic              de_q;
  logic              first_pix_q;
  logic [CORD_W-1:0] prev_sx;
  logic [CORD_W-1:0] prev_sy;
  logic [CORD_W-1:0] exp_sx;
  logic [CORD_W-1:0] exp_sy;
  logic [15:0]       pos_err_q;
  logic              pos_bad;

  // Expectation always derives from the last observed pixel, so one glitch costs one error.
  always_comb begin
    exp_sx = '0;
    exp_sy = '0;
    if (first_pix_q) begin
      exp_sx = '0;
      exp_sy = '0;
    end else if (de_q) begin
      exp_sx = prev_sx + 1'b1;
      exp_sy = prev_sy;
    end else begin
      exp_sx = '0;
      exp_sy = prev_sy + 1'b1;
    end
    pos_bad     = de && ((sx != exp_sx) || (sy != exp_sy));
    pos_err_upd = (pos_bad && pos_err_q != 16'hFFFF) ? pos_err_q + 16'd1 : pos_err_q;
  end

  always_ff @(posedge clk_pix or negedge btn_rst) begin
    if (!btn_rst) begin
      de_q        <= 1'b0;
      first_pix_q <= 1'b1;
      prev_sx     <= '0;
      prev_sy     <= '0;
      pos_err_q   <= '0;
    end else begin
      de_q <= de;
      if (de) begin
        prev_sx <= sx;
        prev_sy <= sy;
      end
      if (frame_end) begin
        first_pix_q <= 1'b1;
        pos_err_q   <= '0;
      end else begin
        if (de) first_pix_q <= 1'b0;
        pos_err_q <= pos_err_upd;
      end
    end
  end
`else
  logic unused_coords;

  assign unused_coords = ^{sx, sy};
  assign pos_err_upd   = '0;
`endif

  always_comb begin
    rec_in         = '0;
    rec_in.frame   = frame_q;
    rec_in.pix_cnt = REC_CNT_W'(cnt_upd);
    rec_in.crc     = crc_upd ^ CRC_XOR;
    rec_in.partial = partial_q;
    rec_in.pos_err = pos_err_upd;
  end

  frame_crc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_pix),
    .rst_n (btn_rst),
    .push  (frame_end),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Record fields read as zero whenever nothing is queued.
  assign shown         = fifo_empty ? '0 : rec_head;
  assign unused_cnt_hi = ^shown.pix_cnt;

  assign out_valid   = !fifo_empty;
  assign out_frame   = shown.frame;
  assign out_pix_cnt = shown.pix_cnt[PIX_CNT_W-1:0];
  assign out_crc     = shown.crc;
  assign out_partial = shown.partial;
  assign out_pos_err = shown.pos_err;

endmodule

// File: tb/tb_frame_crc_monitor.sv
// Directed self-checking bench for frame_crc_monitor (small frames, 6-bit pixel counter).
// Coordinate-checker cases are compiled when FRAME_CRC_POS_CHECK_EN is defined.
module tb_frame_crc_monitor;

  localparam int COLOR_W   = 4;
  localparam int CORD_W    = 10;
  localparam int PIX_CNT_W = 6;
  localparam int DEPTH     = 4;
  localparam int CNT_MAX   = (1 << PIX_CNT_W) - 1;

  logic                 clk_pix   = 1'b0;
  logic                 btn_rst   = 1'b0;
  logic                 de        = 1'b0;
  logic                 vsync     = 1'b1;
  logic                 out_ready = 1'b1;
  logic [CORD_W-1:0]    sx        = '0;
  logic [CORD_W-1:0]    sy        = '0;
  logic [COLOR_W-1:0]   r         = '0;
  logic [COLOR_W-1:0]   g         = '0;
  logic [COLOR_W-1:0]   b         = '0;
  logic                 out_valid;
  logic [15:0]          out_frame;
  logic [PIX_CNT_W-1:0] out_pix_cnt;
  logic [31:0]          out_crc;
  logic                 out_partial;
  logic [15:0]          out_pos_err;
  logic                 overflow;
  logic [7:0]           drop_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_crc;
  int          m_cnt;

  always #5 clk_pix = ~clk_pix;

  frame_crc_monitor #(
    .COLOR_W   (COLOR_W),
    .CORD_W    (CORD_W),
    .PIX_CNT_W (PIX_CNT_W),
    .DEPTH     (DEPTH),
    .VSYNC_ACT (1'b0)
  ) dut (
    .clk_pix     (clk_pix),
    .btn_rst     (btn_rst),
    .de          (de),
    .vsync       (vsync),
    .sx          (sx),
    .sy          (sy),
    .r           (r),
    .g           (g),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_frame   (out_frame),
    .out_pix_cnt (out_pix_cnt),
    .out_crc     (out_crc),
    .out_partial (out_partial),
    .out_pos_err (out_pos_err),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled at that same falling edge.
  task automatic applyStimulus(input logic de_v, input logic vs_v, input int x, input int y,
                               input logic [11:0] word);
    @(negedge clk_pix);
    de    = de_v;
    vsync = vs_v;
    sx    = CORD_W'(x);
    sy    = CORD_W'(y);
    {r, g, b} = word;
  endtask

  function automatic logic [31:0] ref_crc_word(input logic [31:0] c_in, input logic [11:0] w);
    logic [31:0] c;
    c = c_in;
    for (int k = 11; k >= 0; k--) begin
      if (c[31] ^ w[k]) c = (c << 1) ^ 32'h04C11DB7;
      else              c = c << 1;
    end
    return c;
  endfunction

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 0, 0, 12'h000);
  endtask

  task automatic pixel(input int x, input int y, input logic [11:0] word, input logic vs_v);
    applyStimulus(1'b1, vs_v, x, y, word);
    m_crc = ref_crc_word(m_crc, word);
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  // One-cycle vsync pulse; returns at the falling edge where the new record is visible.
  task automatic frame_pulse();
    applyStimulus(1'b0, 1'b0, 0, 0, 12'h000);
    idle();
  endtask

  task automatic send_frame(input int w, input int h, input int seed);
    m_crc = 32'hFFFFFFFF;
    m_cnt = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) pixel(x, y, 12'(x * 7 + y * 13 + seed), 1'b1);
      idle();
    end
    frame_pulse();
    m_crc = m_crc ^ 32'hFFFFFFFF;
  endtask

  task automatic check_record(input string tag, input int frame, input int cnt,
                              input logic [31:0] crc, input logic partial, input int pos_err);
    checkOutput({tag, "_valid"},   32'(out_valid),   32'd1);
    checkOutput({tag, "_frame"},   32'(out_frame),   32'(frame));
    checkOutput({tag, "_cnt"},     32'(out_pix_cnt), 32'(cnt));
    checkOutput({tag, "_crc"},     out_crc,          crc);
    checkOutput({tag, "_partial"}, 32'(out_partial), 32'(partial));
    checkOutput({tag, "_poserr"},  32'(out_pos_err), 32'(pos_err));
  endtask

  task automatic check_cleared(input string tag);
    checkOutput({tag, "_valid"},    32'(out_valid),   32'd0);
    checkOutput({tag, "_frame"},    32'(out_frame),   32'd0);
    checkOutput({tag, "_cnt"},      32'(out_pix_cnt), 32'd0);
    checkOutput({tag, "_crc"},      out_crc,          32'd0);
    checkOutput({tag, "_partial"},  32'(out_partial), 32'd0);
    checkOutput({tag, "_poserr"},   32'(out_pos_err), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow),    32'd0);
    checkOutput({tag, "_drops"},    32'(drop_cnt),    32'd0);
  endtask

  task automatic do_reset();
    idle();
    btn_rst = 1'b0;
    idle();
    idle();
    idle();
    btn_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] bz [6];
    bz = '{12'h313, 12'h233, 12'h343, 12'h536, 12'h373, 12'h839};

    idle();
    idle();
    idle();
    check_cleared("rst");
    btn_rst = 1'b1;

    // "123456789" as six 12-bit pixels; last one lands on the frame-end cycle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, i, 0, bz[i]);
    applyStimulus(1'b1, 1'b0, 5, 0, bz[5]);
    idle();
    check_record("bzip", 0, 6, 32'hFC891918, 1'b1, 0);
    idle();
    checkOutput("popped_valid", 32'(out_valid), 32'd0);

    send_frame(8, 4, 3);
    check_record("f1", 1, 32, m_crc, 1'b0, 0);
    send_frame(8, 4, 100);
    check_record("f2", 2, 32, m_crc, 1'b0, 0);
    send_frame(5, 3, 77);
    check_record("f3", 3, 15, m_crc, 1'b0, 0);
    send_frame(10, 8, 9);
    check_record("sat", 4, CNT_MAX, m_crc, 1'b0, 0);

    frame_pulse();
    check_record("empty1", 5, 0, 32'h00000000, 1'b0, 0);
    frame_pulse();
    check_record("empty2", 6, 0, 32'h00000000, 1'b0, 0);

    // Overflow: six frame ends with no consumer, four records fit.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) frame_pulse();
    check_record("ovf_head", 0, 0, 32'h0, 1'b1, 0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drops", 32'(drop_cnt), 32'd2);
    idle();
    checkOutput("ovf_hold", 32'(out_frame), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_%0d", i), 32'(out_frame), 32'(i));
      idle();
    end
    checkOutput("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO with pop and frame end on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) frame_pulse();
    checkOutput("full_head", 32'(out_frame), 32'd6);
    applyStimulus(1'b0, 1'b0, 0, 0, 12'h000);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    checkOutput("sim_drops", 32'(drop_cnt), 32'd2);
    checkOutput("sim_head", 32'(out_frame), 32'd7);
    out_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      checkOutput($sformatf("sim_drain_%0d", i), 32'(out_frame), 32'(i));
      idle();
    end
    checkOutput("sim_empty", 32'(out_valid), 32'd0);

    // Reset mid-frame with a pending record and a sticky overflow.
    out_ready = 1'b0;
    frame_pulse();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, i, 0, 12'hABC);
    btn_rst = 1'b0;
    idle();
    idle();
    idle();
    check_cleared("midrst");
    btn_rst   = 1'b1;
    out_ready = 1'b1;
    send_frame(4, 2, 21);
    check_record("after_rst", 0, 8, m_crc, 1'b1, 0);

`ifdef FRAME_CRC_POS_CHECK_EN
    begin
      int xs [8];
      xs = '{0, 1, 2, 3, 4, 5, 7, 8};
      m_crc = 32'hFFFFFFFF;
      m_cnt = 0;
      for (int i = 0; i < 8; i++) pixel(xs[i], 0, 12'(xs[i] * 5 + 1), 1'b1);
      idle();
      for (int x = 0; x < 8; x++) pixel(x, 1, 12'(x * 3 + 2), 1'b1);
      idle();
      frame_pulse();
      m_crc = m_crc ^ 32'hFFFFFFFF;
      check_record("posskip", 1, 16, m_crc, 1'b0, 1);
      send_frame(4, 2, 5);
      check_record("posclean", 2, 8, m_crc, 1'b0, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_crc_monitor.md
# frame_crc_monitor

Synthesisable, parametrised pixel-stream monitor on the `clk_pix` domain of `display_driver`. It taps `de`/`sx`/`sy`/RGB and computes a CRC-32 signature and pixel count per frame. Each completed frame's record is queued in a small FIFO and drained over a valid/ready stream. It replaces file-dump frame capture for on-chip and long-run regression checking.

## Interface
Parameters:
- `COLOR_W`, 4: bits per colour channel; pixel word = {r,g,b}, 3*COLOR_W bits
- `CORD_W`, 10: width of `sx`/`sy`
- `PIX_CNT_W`, 20: pixel counter width
- `DEPTH`, 4: record FIFO depth, power of two ≥2
- `VSYNC_ACT`, 0: active level of `vsync`

Ports:
- `clk_pix` in 1: pixel clock
- `btn_rst` in 1: asynchronous, active-low reset
- `de` in 1: data enable, pixel valid
- `vsync` in 1: vertical sync
- `sx`, `sy` in CORD_W: current pixel coordinates
- `r`, `g`, `b` in COLOR_W: pixel colour
- `out_valid` out 1: record available
- `out_ready` in 1: consumer accepts record
- `out_frame` out 16: frame index, wraps 0xFFFF→0
- `out_pix_cnt` out PIX_CNT_W: de-cycles in frame, saturating
- `out_crc` out 32: frame CRC
- `out_partial` out 1: frame started before reset release
- `out_pos_err` out 16: position-check violations, saturating
- `overflow` out 1: sticky, a record was dropped
- `drop_cnt` out 8: dropped records, saturating at 0xFF

## Operation
- CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, MSB-first, one full pixel word per `de` cycle (parallel update).
- Frame end = cycle where `vsync` sampled == VSYNC_ACT and previous sample != VSYNC_ACT (registered edge detect; `vsync_q` resets to !VSYNC_ACT).
- On frame end: record {frame idx, count, finalised CRC, partial, pos_err} pushed; CRC, count, pos_err re-init same edge; frame idx increments whether or not push succeeds.
- Pixel with `de`=1 on the frame-end cycle belongs to the closing frame.
- Zero-pixel frame: count 0, CRC 0x00000000.
- FIFO full on push, no simultaneous pop: record dropped, `overflow` set, `drop_cnt`++. Full with simultaneous pop: push accepted.
- First frame after reset release has `out_partial`=1; later frames 0.
- Count saturates at all-ones; CRC continues.

## Timing
- Reset: all outputs 0, FIFO empty, frame idx 0, CRC reg 0xFFFFFFFF.
- Frame end at cycle N → record in FIFO at end of N; `out_valid`=1 in N+1 if FIFO was empty (first-word fall-through).
- Pop on `out_valid && out_ready` at a rising edge; next record visible the following cycle.
- Outputs stable while `out_valid && !out_ready`.
- Reset mid-frame: accumulators and FIFO cleared immediately; `overflow`/`drop_cnt` cleared.

## Configuration
- `FRAME_CRC_POS_CHECK_EN` defined: each `de` pixel checked. Expected (0,0) as first pixel of frame; within a line `sx` = prev+1, `sy` unchanged; new line (de rising) expects `sx`=0, `sy`=prev+1. Each mismatch increments pos_err (saturating); expectation then resyncs to observed coordinates.
- Not defined: checker absent, `out_pos_err` tied 0, `sx`/`sy` unused.

## Structure
- Package `frame_crc_pkg`: CRC_POLY, CRC_INIT, CRC_XOR constants; `frame_rec_t` packed struct (frame, pix_cnt, crc, partial, pos_err); function `crc32_next(crc, data)` generic over data width.
- Sub-module `frame_crc_fifo`: synchronous FWFT FIFO of `frame_rec_t`, DEPTH entries, push/pop/full/empty.

## Test plan
- Reset, then 3 frames of 640×480 with `de` patterns, `out_ready`=1 → records frame 0,1,2; pix_cnt 307200; frame 0 partial=1, frames 1,2 partial=0; CRC equals bench reference model.
- Two consecutive vsync edges with no `de` → record pix_cnt 0, CRC 0x00000000.
- `out_ready`=0, 6 frame ends, DEPTH=4 → 4 records held (frames 0–3), `overflow`=1, `drop_cnt`=2; drain yields frames 0,1,2,3.
- FIFO full, pop and frame end on same edge → no drop, `drop_cnt` unchanged, new record last in order.
- `btn_rst` low mid-frame for 3 cycles → all outputs 0; next record frame 0, partial=1.
- With `FRAME_CRC_POS_CHECK_EN`, one line skipping `sx` 5→7 → `out_pos_err`=1; clean frame → 0.
